// File: rtl/fp32_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp32_multiplier_seq
// Description : Sequential IEEE-754 binary32 multiplier (z = a * b) with a
//               start/busy/done handshake. Special operands are resolved in
//               UNPACK; finite products use an iterative shift-add mantissa
//               multiply followed by round-to-nearest-even.
//               Optional exception flags are built when FP_MUL_FLAGS_EN is
//               defined; the result datapath is identical either way.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_multiplier_seq #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] output_z
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  localparam int unsigned c_n_steps = 24 / BITS_PER_CYCLE;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MUL    = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [47:0]        mcand_q, mcand_d;
  logic [23:0]        mplier_q, mplier_d;
  logic [47:0]        acc_q, acc_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        z_q, z_d;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]         flags_q, flags_d;
`endif

  // Leading-zero count of a 24-bit mantissa (24 when zero).
  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  // Mantissa with the leading one at bit 23; subnormals are left-normalised.
  function automatic logic [23:0] norm_mant(input logic [31:0] x);
    if (x[30:23] == 8'd0) return {1'b0, x[22:0]} << lzc24({1'b0, x[22:0]});
    else                  return {1'b1, x[22:0]};
  endfunction

  // Biased exponent matching norm_mant (1-lz for subnormals).
  function automatic logic signed [9:0] eff_exp(input logic [31:0] x);
    if (x[30:23] == 8'd0) return 10'sd1 - signed'({5'd0, lzc24({1'b0, x[22:0]})});
    else                  return signed'({2'b00, x[30:23]});
  endfunction

  // Operand classification and special-case result from the latched operands.
  logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic              w_sign, w_special;
  logic [31:0]       w_special_z;
  logic signed [9:0] w_exp_sum;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]        w_special_flags;
`endif
  always_comb begin
    w_a_nan     = (a_q[30:23] == 8'hff) && (a_q[22:0] != 23'd0);
    w_b_nan     = (b_q[30:23] == 8'hff) && (b_q[22:0] != 23'd0);
    w_a_inf     = (a_q[30:23] == 8'hff) && (a_q[22:0] == 23'd0);
    w_b_inf     = (b_q[30:23] == 8'hff) && (b_q[22:0] == 23'd0);
    w_a_zero    = (a_q[30:0] == 31'd0);
    w_b_zero    = (b_q[30:0] == 31'd0);
    w_sign      = a_q[31] ^ b_q[31];
    w_exp_sum   = eff_exp(a_q) + eff_exp(b_q) - 10'sd127;
    w_special   = 1'b1;
    w_special_z = 32'd0;
`ifdef FP_MUL_FLAGS_EN
    w_special_flags = 4'd0;
`endif
    if (w_a_nan || w_b_nan) begin
      // The first NaN operand propagates, quietened.
      w_special_z = w_a_nan ? {a_q[31], 8'hff, 1'b1, a_q[21:0]}
                            : {b_q[31], 8'hff, 1'b1, b_q[21:0]};
`ifdef FP_MUL_FLAGS_EN
      w_special_flags[3] = (w_a_nan && !a_q[22]) || (w_b_nan && !b_q[22]);
`endif
    end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
      w_special_z = 32'h7fc0_0000;
`ifdef FP_MUL_FLAGS_EN
      w_special_flags[3] = 1'b1;
`endif
    end else if (w_a_inf || w_b_inf) begin
      w_special_z = {w_sign, 8'hff, 23'd0};
    end else if (w_a_zero || w_b_zero) begin
      w_special_z = {w_sign, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  // Partial product for the multiplier bits retired this cycle.
  logic [47:0] w_pp;
  always_comb begin
    w_pp = 48'd0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier_q[k]) w_pp = w_pp + (mcand_q << k);
    end
  end

  // Normalise, denormalise if tiny, round to nearest-even and pack.
  logic [47:0]       w_pn, w_v;
  logic signed [9:0] w_e_norm, w_sh_full, w_e_fin;
  logic              w_tiny, w_flush, w_lost, w_g, w_r, w_s, w_up;
  logic [4:0]        w_sh;
  logic [23:0]       w_mant;
  logic [24:0]       w_mr;
  logic [31:0]       w_round_z;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]        w_round_flags;
  logic              w_inexact;
`endif
  always_comb begin
    w_pn      = acc_q[47] ? acc_q : {acc_q[46:0], 1'b0};
    w_e_norm  = exp_q + (acc_q[47] ? 10'sd1 : 10'sd0);
    w_sh_full = 10'sd1 - w_e_norm;
    w_tiny    = (w_e_norm < 10'sd1);
    w_flush   = w_tiny && (w_sh_full > 10'sd25);
    w_sh      = (w_tiny && !w_flush) ? w_sh_full[4:0] : 5'd0;
    w_v       = w_pn >> w_sh;
    w_lost    = |(w_pn & ((48'd1 << w_sh) - 48'd1));
    w_mant    = w_v[47:24];
    w_g       = w_v[23];
    w_r       = w_v[22];
    w_s       = (|w_v[21:0]) | w_lost;
    w_up      = w_g & (w_r | w_s | w_mant[0]);
    w_mr      = {1'b0, w_mant} + {24'd0, w_up};
    w_e_fin   = w_e_norm + (w_mr[24] ? 10'sd1 : 10'sd0);
`ifdef FP_MUL_FLAGS_EN
    w_inexact     = w_g | w_r | w_s;
    w_round_flags = {3'b000, w_inexact};
`endif
    if (w_flush) begin
      w_round_z = {sign_q, 31'd0};
`ifdef FP_MUL_FLAGS_EN
      w_round_flags = 4'b0011;
`endif
    end else if (w_tiny) begin
      // A carry into bit 23 lands in the exponent field: minimum normal.
      w_round_z = {sign_q, 6'd0, w_mr};
`ifdef FP_MUL_FLAGS_EN
      w_round_flags = {2'b00, w_inexact, w_inexact};
`endif
    end else if (w_e_fin >= 10'sd255) begin
      w_round_z = {sign_q, 8'hff, 23'd0};
`ifdef FP_MUL_FLAGS_EN
      w_round_flags = 4'b0101;
`endif
    end else begin
      w_round_z = {sign_q, w_e_fin[7:0], w_mr[22:0]};
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    z_d      = z_q;
`ifdef FP_MUL_FLAGS_EN
    flags_d  = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = input_a;
          b_d     = input_b;
          busy_d  = 1'b1;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d = w_sign;
        if (w_special) begin
          z_d     = w_special_z;
`ifdef FP_MUL_FLAGS_EN
          flags_d = w_special_flags;
`endif
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          mcand_d  = {24'd0, norm_mant(a_q)};
          mplier_d = norm_mant(b_q);
          acc_d    = 48'd0;
          exp_d    = w_exp_sum;
          cnt_d    = 5'(c_n_steps - 1);
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        acc_d    = acc_q + w_pp;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = S_ROUND;
      end
      S_ROUND: begin
        z_d     = w_round_z;
`ifdef FP_MUL_FLAGS_EN
        flags_d = w_round_flags;
`endif
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset also aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      mcand_q  <= 48'd0;
      mplier_q <= 24'd0;
      acc_q    <= 48'd0;
      cnt_q    <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      z_q      <= 32'd0;
`ifdef FP_MUL_FLAGS_EN
      flags_q  <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      z_q      <= z_d;
`ifdef FP_MUL_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign output_z = z_q;
`ifdef FP_MUL_FLAGS_EN
  assign flags    = flags_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp32_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_multiplier_seq
// Description : Directed self-checking bench for fp32_multiplier_seq with
//               hand-computed expected products, latencies and flags.
//               Flag checks are built when FP_MUL_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_multiplier_seq;

  logic        clk;
  logic        rst;
  logic [31:0] input_a, input_b;
  logic        start, start4;
  logic        busy, done, busy4, done4;
  logic [31:0] output_z, output_z4;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]  flags, flags4;
`endif

  int compared = 0;
  int mismatched = 0;

  fp32_multiplier_seq #(.BITS_PER_CYCLE(1)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .input_a  (input_a),
    .input_b  (input_b),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .output_z (output_z)
`ifdef FP_MUL_FLAGS_EN
    ,
    .flags    (flags)
`endif
  );

  fp32_multiplier_seq #(.BITS_PER_CYCLE(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .input_a  (input_a),
    .input_b  (input_b),
    .start    (start4),
    .busy     (busy4),
    .done     (done4),
    .output_z (output_z4)
`ifdef FP_MUL_FLAGS_EN
    ,
    .flags    (flags4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation on the default instance; inputs are scrambled after
  // acceptance so the result must come from the latched operands.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_z, input logic [3:0] exp_f);
    int cyc;
    @(negedge clk);
    input_a = a;
    input_b = b;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    input_a = 32'hdead_beef;
    input_b = 32'h1234_5678;
    cyc     = 1;
    check({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " z"}, output_z, exp_z);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
`ifdef FP_MUL_FLAGS_EN
    check({tag, " flags"}, {28'd0, flags}, {28'd0, exp_f});
`endif
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, " z_held"}, output_z, exp_z);
  endtask

  initial begin
    int cyc;
    logic saw_done;
    rst     = 1'b1;
    start   = 1'b0;
    start4  = 1'b0;
    input_a = 32'd0;
    input_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset z", output_z, 32'd0);
`ifdef FP_MUL_FLAGS_EN
    check("reset flags", {28'd0, flags}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    run_op("t1_1p5x2",     32'h3fc0_0000, 32'h4000_0000, 27, 32'h4040_0000, 4'b0000);
    run_op("t2_infx0",     32'h7f80_0000, 32'h0000_0000,  2, 32'h7fc0_0000, 4'b1000);
    run_op("t3_overflow",  32'h7f7f_ffff, 32'h4000_0000, 27, 32'h7f80_0000, 4'b0101);
    run_op("t4_sub_exact", 32'h0080_0000, 32'h3f00_0000, 27, 32'h0040_0000, 4'b0000);
    run_op("t4_sub_tie",   32'h0000_0001, 32'h3f00_0000, 27, 32'h0000_0000, 4'b0011);
    run_op("t5_inexact",   32'h3f80_0001, 32'h3f80_0001, 27, 32'h3f80_0002, 4'b0001);
    run_op("t5_snan",      32'h7fa0_0000, 32'h3f80_0000,  2, 32'h7fe0_0000, 4'b1000);
    run_op("neg_m2x1p5",   32'hc000_0000, 32'h3fc0_0000, 27, 32'hc040_0000, 4'b0000);
    run_op("max_mant_sq",  32'h3fff_ffff, 32'h3fff_ffff, 27, 32'h407f_fffe, 4'b0001);
    run_op("ninf_x2",      32'hff80_0000, 32'h4000_0000,  2, 32'hff80_0000, 4'b0000);
    run_op("nzero_x1",     32'h8000_0000, 32'h3f80_0000,  2, 32'h8000_0000, 4'b0000);

    // Abort 5 clocks into an operation: no done pulse, z cleared.
    saw_done = 1'b0;
    @(negedge clk);
    input_a = 32'h3fc0_0000;
    input_b = 32'h4000_0000;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | done;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort z", output_z, 32'd0);
`ifdef FP_MUL_FLAGS_EN
    check("abort flags", {28'd0, flags}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | done;
    end
    check("abort no_done", {31'd0, saw_done}, 32'd0);
    check("abort idle_busy", {31'd0, busy}, 32'd0);

    // A start pulsed mid-operation with new operands must be ignored.
    @(negedge clk);
    input_a = 32'h3fc0_0000;
    input_b = 32'h4000_0000;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    @(negedge clk);
    input_a = 32'h4000_0000;
    input_b = 32'h4040_0000;
    start   = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("busy_start latency", 32'(cyc), 32'd27);
    check("busy_start z", output_z, 32'h4040_0000);
    repeat (3) @(posedge clk);
    #1;
    check("busy_start no_restart", {31'd0, busy}, 32'd0);

    // Four multiplier bits per cycle: done at clock 9.
    @(negedge clk);
    input_a = 32'h3fc0_0000;
    input_b = 32'h4000_0000;
    start4  = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    cyc    = 1;
    while (!done4 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("bpc4 latency", 32'(cyc), 32'd9);
    check("bpc4 z", output_z4, 32'h4040_0000);
    check("bpc4 busy", {31'd0, busy4}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
